test_status_monitor: RTL and testbench
======================================

TEST_STATUS_MONITOR -- requirements
Module: test_status_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 1: number of monitored hart/CSR channels (1..16).
REQ-002 SHALL have parameter DATA_W, default 32: CSR write data width (>=2).
REQ-003 SHALL have parameter CNT_W, default 32: width of the cycle counter and the captured cycle count.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 10: cycles ignored after reset release.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 100000: run cycles before timeout.
REQ-006 SHALL have parameter DRAIN_CYCLES, default 100: cycles from verdict to finish.
REQ-007 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-008 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port csr_we, input, NUM_CH: per-channel CSR (tohost) write strobe.
REQ-010 SHALL have port csr_wdata, input, NUM_CH*DATA_W: per-channel write data; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port state, output, 2: IDLE=0, RUN=1, DRAIN=2, FINISH=3.
REQ-012 SHALL have port done, output, 1: a verdict has been reached (sticky).
REQ-013 SHALL have port pass, output, 1: all channels passed (sticky).
REQ-014 SHALL have port fail, output, 1: some channel reported failure (sticky).
REQ-015 SHALL have port timeout, output, 1: timeout expired before a verdict (sticky).
REQ-016 SHALL have port fail_ch, output, $clog2(NUM_CH) (min 1): index of the failing channel.
REQ-017 SHALL have port fail_code, output, DATA_W-1: csr_wdata[DATA_W-1:1] of the failing write.
REQ-018 SHALL have port cycle_cnt, output, CNT_W: cycles since reset release.
REQ-019 SHALL have port verdict_cycle, output, CNT_W: cycle_cnt value in the verdict cycle.
REQ-020 SHALL have port finish, output, 1: single-cycle pulse on entry to FINISH.

Function
REQ-021 SHALL treat a write as terminal only when csr_we[i]=1 and wdata[0]=1; SHALL classify wdata==1 as PASS and any other odd value as FAIL; SHALL ignore even values.
REQ-022 SHALL count cycle_cnt +1 every cycle while rst=0, saturating at all-ones.
REQ-023 SHALL, in IDLE, count SETTLE_CYCLES cycles ignoring all writes, then enter RUN; SETTLE_CYCLES=0 enters RUN on the first post-reset cycle.
REQ-024 SHALL, in RUN, keep one sticky passed bit per channel, set by that channel's PASS write; repeated PASS writes have no further effect.
REQ-025 SHALL, on any FAIL in RUN, set fail=1 and done=1, capture fail_ch, fail_code and verdict_cycle, and enter DRAIN on the next cycle.
REQ-026 SHALL resolve simultaneous FAILs to the lowest channel index; FAIL SHALL win over a simultaneous PASS completing the set.
REQ-027 SHALL set pass=1 and done=1 in the cycle in which all NUM_CH passed bits (including same-cycle writes) become set, capture verdict_cycle, and enter DRAIN.
REQ-028 SHALL count RUN cycles and, when the count reaches TIMEOUT_CYCLES with no verdict, set timeout=1 and done=1, capture verdict_cycle, and enter DRAIN; a terminal write in that same cycle SHALL take precedence over timeout.
REQ-029 SHALL ignore all csr_we activity in DRAIN and FINISH; sticky flags and captured fields SHALL remain frozen until reset.
REQ-030 SHALL count DRAIN_CYCLES in DRAIN, then enter FINISH and pulse finish for one cycle; DRAIN_CYCLES=0 enters FINISH the cycle after the verdict.
REQ-031 SHALL remain in FINISH until rst.
REQ-032 SHALL keep pass, fail and timeout mutually exclusive at all times.

Reset
REQ-033 SHALL, while rst=1, force state=IDLE, clear all counters and passed bits, and drive done, pass, fail, timeout, finish, fail_ch, fail_code, cycle_cnt and verdict_cycle to 0.
REQ-034 SHALL, when rst is asserted in any state, abort the operation in progress and restart from IDLE with no residual verdict.

Verification
REQ-035 NUM_CH=1, SETTLE=10: write 1 at cycle 5 (ignored), write 1 at cycle 20 -> pass=1, verdict_cycle=20, finish pulse at cycle 20+DRAIN+1.
REQ-036 NUM_CH=4: channels 0,2,3 write 1 and channel 1 writes 0x7 (code 3) in the same cycle -> fail=1, fail_ch=1, fail_code=3, pass=0.
REQ-037 NUM_CH=2: ch0 writes 1, ch1 writes 2 (even, ignored), ch1 writes 1 later -> pass set in ch1's write cycle only.
REQ-038 TIMEOUT=50, no writes -> timeout=1 in RUN cycle 50; a write of 1 in that same cycle -> pass=1, timeout=0.
REQ-039 Assert rst during DRAIN after a fail -> all outputs 0, state=IDLE; a subsequent pass run completes normally.
REQ-040 Writes of 0x5 after the verdict -> no change to fail_code, fail_ch or the flags.

Source files
------------

// File: rtl/test_status_monitor.sv
// test_status_monitor: watches per-channel tohost CSR writes and produces a sticky pass/fail/timeout verdict.
// Ports: clk, rst (sync, active-high); csr_we/csr_wdata per-channel write strobes and data;
// state (IDLE/RUN/DRAIN/FINISH), done/pass/fail/timeout sticky verdict flags, fail_ch/fail_code
// of the failing write, cycle_cnt since reset release, verdict_cycle captured at verdict, finish pulse.
module test_status_monitor #(
    parameter int NUM_CH         = 1,
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 32,
    parameter int SETTLE_CYCLES  = 10,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int DRAIN_CYCLES   = 100
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_CH-1:0]                       csr_we,
    input  logic [NUM_CH*DATA_W-1:0]                csr_wdata,
    output logic [1:0]                              state,
    output logic                                    done,
    output logic                                    pass,
    output logic                                    fail,
    output logic                                    timeout,
    output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] fail_ch,
    output logic [DATA_W-2:0]                       fail_code,
    output logic [CNT_W-1:0]                        cycle_cnt,
    output logic [CNT_W-1:0]                        verdict_cycle,
    output logic                                    finish
);
    localparam int FW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;
    // With no drain phase the verdict goes straight to FINISH.
    localparam state_t POST = DRAIN_CYCLES == 0 ? FINISH : DRAIN;
    state_t            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [NUM_CH-1:0] passed_q, passed_d, pass_hit, fail_hit;
    logic              done_q, done_d, pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d, finish_q, finish_d;
    logic [FW-1:0]     fail_ch_q, fail_ch_d, fidx;
    logic [DATA_W-2:0] fail_code_q, fail_code_d, fcode;
    logic [CNT_W-1:0]  cycle_q, verdict_q, verdict_d;

    // Per-channel decode; the reverse scan leaves the lowest failing channel in fidx/fcode.
    always_comb begin
        pass_hit = '0;
        fail_hit = '0;
        fidx     = '0;
        fcode    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            pass_hit[i] = csr_we[i] && csr_wdata[i*DATA_W +: DATA_W] == DATA_W'(1);
            fail_hit[i] = csr_we[i] && csr_wdata[i*DATA_W] && !pass_hit[i];
            if (fail_hit[i]) begin
                fidx  = FW'(i);
                fcode = csr_wdata[i*DATA_W+1 +: DATA_W-1];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 32'd1;
        passed_d    = passed_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        tmo_d       = tmo_q;
        fail_ch_d   = fail_ch_q;
        fail_code_d = fail_code_q;
        verdict_d   = verdict_q;
        case (state_q)
            IDLE: if (SETTLE_CYCLES == 0 || cnt_q == 32'(SETTLE_CYCLES - 1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                passed_d = passed_q | pass_hit;
                // Priority: fail, then completed pass set, then timeout.
                if (|fail_hit) begin
                    fail_d      = 1'b1;
                    fail_ch_d   = fidx;
                    fail_code_d = fcode;
                end else if (&passed_d) begin
                    pass_d = 1'b1;
                end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d = 1'b1;
                end
                if (|fail_hit || &passed_d || cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    done_d    = 1'b1;
                    verdict_d = cycle_q;
                    state_d   = POST;
                    cnt_d     = '0;
                end
            end
            DRAIN: state_d = cnt_q == 32'(DRAIN_CYCLES - 1) ? FINISH : DRAIN;
            default: state_d = FINISH;
        endcase
        finish_d = state_d == FINISH && state_q != FINISH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            passed_q    <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            tmo_q       <= 1'b0;
            finish_q    <= 1'b0;
            fail_ch_q   <= '0;
            fail_code_q <= '0;
            cycle_q     <= '0;
            verdict_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            passed_q    <= passed_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            tmo_q       <= tmo_d;
            finish_q    <= finish_d;
            fail_ch_q   <= fail_ch_d;
            fail_code_q <= fail_code_d;
            cycle_q     <= &cycle_q ? cycle_q : cycle_q + CNT_W'(1);
            verdict_q   <= verdict_d;
        end
    end

    assign state         = state_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail          = fail_q;
    assign timeout       = tmo_q;
    assign fail_ch       = fail_ch_q;
    assign fail_code     = fail_code_q;
    assign cycle_cnt     = cycle_q;
    assign verdict_cycle = verdict_q;
    assign finish        = finish_q;
endmodule

// File: tb/tb_test_status_monitor.sv
// tb_test_status_monitor: directed and randomized checks of test_status_monitor against a cycle-indexed reference model.
module tb_test_status_monitor;
    localparam int NC = 4, DW = 8, CW = 8, ST = 10, TO = 50, DR = 5, MAXC = 300;
    logic           clk = 1'b0, rst = 1'b1;
    logic [NC-1:0]  csr_we = '0;
    logic [NC*DW-1:0] csr_wdata = '0;
    logic [1:0]     state;
    logic           done, pass, fail, timeout, finish;
    logic [1:0]     fail_ch;
    logic [DW-2:0]  fail_code;
    logic [CW-1:0]  cycle_cnt, verdict_cycle;
    int             npass = 0, ntot = 0;
    logic [NC-1:0]  we_tab [MAXC];
    logic [DW-1:0]  wd_tab [MAXC][NC];

    test_status_monitor #(.NUM_CH(NC), .DATA_W(DW), .CNT_W(CW), .SETTLE_CYCLES(ST),
                          .TIMEOUT_CYCLES(TO), .DRAIN_CYCLES(DR)) dut (
        .clk(clk), .rst(rst), .csr_we(csr_we), .csr_wdata(csr_wdata), .state(state),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout), .fail_ch(fail_ch),
        .fail_code(fail_code), .cycle_cnt(cycle_cnt), .verdict_cycle(verdict_cycle), .finish(finish));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        ntot++;
        assert (o === e) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    endtask

    task automatic clear_tab();
        for (int c = 0; c < MAXC; c++) begin
            we_tab[c] = '0;
            for (int h = 0; h < NC; h++) wd_tab[c][h] = '0;
        end
    endtask

    task automatic wr(input int c, input int h, input logic [DW-1:0] v);
        we_tab[c][h] = 1'b1;
        wd_tab[c][h] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        csr_we = '0;
        @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_fail", 32'(fail), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_finish", 32'(finish), 0);
        chk("rst_fail_ch", 32'(fail_ch), 0);
        chk("rst_fail_code", 32'(fail_code), 0);
        chk("rst_cycle_cnt", 32'(cycle_cnt), 0);
        chk("rst_verdict", 32'(verdict_cycle), 0);
        rst = 1'b0;
    endtask

    // Cycle c is the cycle in which cycle_cnt reads c; a verdict reached in cycle v shows on the flags from v+1.
    task automatic run(input int ncyc, input bit rnd);
        int v = -1, kind = 0, mask = 0, ech = 0, ecode = 0, fch, fcd, est;
        for (int c = 0; c < ncyc; c++) begin
            if (rnd) begin
                for (int h = 0; h < NC; h++) begin
                    int r = $urandom_range(0, 9);
                    we_tab[c][h] = $urandom_range(0, 5) == 0;
                    wd_tab[c][h] = r <= 6 ? 8'd1 : r <= 8 ? {7'($urandom_range(0, 127)), 1'b0}
                                                          : {7'($urandom_range(1, 127)), 1'b1};
                end
            end
            csr_we = we_tab[c];
            for (int h = 0; h < NC; h++) csr_wdata[h*DW +: DW] = wd_tab[c][h];
            est = c < ST ? 0 : (v < 0 || c <= v) ? 1 : (c <= v + DR) ? 2 : 3;
            chk("state", 32'(state), 32'(est));
            chk("done", 32'(done), 32'(kind != 0));
            chk("pass", 32'(pass), 32'(kind == 1));
            chk("fail", 32'(fail), 32'(kind == 2));
            chk("timeout", 32'(timeout), 32'(kind == 3));
            chk("finish", 32'(finish), 32'(v >= 0 && c == v + DR + 1));
            chk("cycle_cnt", 32'(cycle_cnt), 32'(c > 255 ? 255 : c));
            chk("verdict_cycle", 32'(verdict_cycle), 32'(v < 0 ? 0 : v));
            chk("fail_ch", 32'(fail_ch), 32'(kind == 2 ? ech : 0));
            chk("fail_code", 32'(fail_code), 32'(kind == 2 ? ecode : 0));
            if (v < 0 && c >= ST) begin
                fch = -1;
                fcd = 0;
                for (int h = 0; h < NC; h++)
                    if (we_tab[c][h] && wd_tab[c][h][0]) begin
                        if (wd_tab[c][h] == 8'd1) mask |= 1 << h;
                        else if (fch < 0) begin
                            fch = h;
                            fcd = int'(wd_tab[c][h]) / 2;
                        end
                    end
                if (fch >= 0) begin
                    v = c; kind = 2; ech = fch; ecode = fcd;
                end else if (mask == (1 << NC) - 1) begin
                    v = c; kind = 1;
                end else if (c - ST + 1 == TO) begin
                    v = c; kind = 3;
                end
            end
            @(posedge clk);
            #1;
        end
        csr_we = '0;
    endtask

    initial begin
        // All channels pass at cycle 20; the cycle-5 writes fall in the settle window.
        do_reset(); clear_tab();
        for (int h = 0; h < NC; h++) begin wr(5, h, 1); wr(20, h, 1); end
        run(30, 0);
        // Channel 1 fails with code 3 alongside passes; later 0x5 writes are ignored.
        do_reset(); clear_tab();
        wr(15, 0, 1); wr(15, 1, 8'h07); wr(15, 2, 1); wr(15, 3, 1);
        wr(17, 1, 8'h05); wr(18, 0, 8'h05); wr(18, 2, 8'h05);
        run(25, 0);
        // Reset lands in DRAIN after a fail, then a normal pass run.
        do_reset(); run(18, 0);
        do_reset(); clear_tab();
        for (int h = 0; h < NC; h++) wr(20, h, 1);
        run(30, 0);
        // Even write on channel 1 is ignored; pass only at its later write of 1.
        do_reset(); clear_tab();
        wr(12, 0, 1); wr(13, 2, 1); wr(13, 3, 1); wr(14, 1, 2); wr(18, 1, 1);
        run(30, 0);
        // No writes: timeout in the 50th RUN cycle.
        do_reset(); clear_tab();
        run(70, 0);
        // Completing pass in the timeout cycle wins over timeout.
        do_reset(); clear_tab();
        wr(11, 0, 1); wr(11, 1, 1); wr(11, 2, 1); wr(59, 3, 1);
        run(70, 0);
        // Simultaneous fails on channels 2 and 3 resolve to channel 2.
        do_reset(); clear_tab();
        wr(20, 1, 1); wr(20, 2, 8'h09); wr(20, 3, 8'h03);
        run(30, 0);
        for (int k = 0; k < 8; k++) begin
            do_reset(); clear_tab();
            run(120, 1);
        end
        // Long run also covers cycle_cnt saturation.
        do_reset(); clear_tab();
        run(MAXC, 1);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
